// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift sequencer: shift-unit control codes,
// request opcodes and FSM state values.
package shift_seq_ctrl_pkg;

   localparam logic [2:0] SC_NOP  = 3'b000;
   localparam logic [2:0] SC_LOAD = 3'b001;
   localparam logic [2:0] SC_SLL  = 3'b010;
   localparam logic [2:0] SC_SRL  = 3'b011;
   localparam logic [2:0] SC_SRA  = 3'b100;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
   localparam logic [2:0] ST_LOAD_ENC    = 3'd1;
   localparam logic [2:0] ST_SHIFT_ENC   = 3'd2;
   localparam logic [2:0] ST_CAPTURE_ENC = 3'd3;
   localparam logic [2:0] ST_FINISH_ENC  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = ST_IDLE_ENC,
      ST_LOAD    = ST_LOAD_ENC,
      ST_SHIFT   = ST_SHIFT_ENC,
      ST_CAPTURE = ST_CAPTURE_ENC,
      ST_FINISH  = ST_FINISH_ENC
   } state_t;

   function automatic logic [2:0] op_to_sc(input logic [1:0] op);
      case (op)
         OP_SRL:  return SC_SRL;
         OP_SRA:  return SC_SRA;
         default: return SC_SLL;
      endcase
   endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between the multicycle control unit (master)
// and the shift sequencer (slave).
interface shift_seq_ctrl_if #(
   parameter int AMT_W = 5
);
   logic             start;
   logic [1:0]       op;
   logic [31:0]      src;
   logic [AMT_W-1:0] amt;
   logic             abort;
   logic             busy;
   logic             done;
   logic             err;
   logic [31:0]      result;

   modport master (output start, op, src, amt, abort,
                   input  busy, done, err, result);
   modport slave  (input  start, op, src, amt, abort,
                   output busy, done, err, result);
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequences one shift request onto the shift register unit: load, one or
// more shift steps, capture, then a single done pulse with the result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands latched on acceptance
// LOAD    | shift unit loads latched src (ShiftControl = 001)
// SHIFT   | one step of min(remaining, STEP_MAX) per cycle
// CAPTURE | shift unit idle; result taken from Shift_reg_out at edge
// FINISH  | done pulse (err too when the op was invalid)
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int AMT_W    = 5,
   parameter int STEP_MAX = 31
) (
   input  logic             clk,
   input  logic             reset_n,
   shift_seq_ctrl_if.slave  req,
   input  logic [31:0]      Shift_reg_out,
   output logic [2:0]       ShiftControl,
   output logic [31:0]      Shift_source,
   output logic [31:0]      Shift_amount
);

   localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [31:0]      src_q, src_d;
   logic [AMT_W-1:0] rem_q, rem_d, step_cur;
   logic             inv_q, inv_d;
   logic [2:0]       sc_q, sc_d;
   logic [AMT_W-1:0] samt_q, samt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [31:0]      res_q;

   assign step_cur = (rem_q > STEP_LIM) ? STEP_LIM : rem_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      src_d   = src_q;
      rem_d   = rem_q;
      inv_d   = inv_q;
      sc_d    = SC_NOP;
      samt_d  = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req.start && !req.abort) begin
               op_d    = req.op;
               src_d   = req.src;
               rem_d   = req.amt;
               inv_d   = (req.op == 2'b11);
               state_d = (req.op == 2'b11) ? ST_FINISH : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (req.abort)           state_d = ST_IDLE;
            else if (rem_q == '0)    state_d = ST_CAPTURE;
            else                     state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (req.abort) begin
               state_d = ST_IDLE;
            end else begin
               rem_d   = rem_q - step_cur;
               state_d = (rem_d != '0) ? ST_SHIFT : ST_CAPTURE;
            end
         end
         ST_CAPTURE: state_d = req.abort ? ST_IDLE : ST_FINISH;
         ST_FINISH:  state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they appear as flops
      // aligned with the state they belong to.
      case (state_d)
         ST_IDLE:  busy_d = 1'b0;
         ST_LOAD:  sc_d   = SC_LOAD;
         ST_SHIFT: begin
            sc_d   = op_to_sc(op_d);
            samt_d = (rem_d > STEP_LIM) ? STEP_LIM : rem_d;
         end
         ST_FINISH: begin
            done_d = 1'b1;
            err_d  = inv_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         src_q   <= '0;
         rem_q   <= '0;
         inv_q   <= 1'b0;
         sc_q    <= SC_NOP;
         samt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_q   <= src_d;
         rem_q   <= rem_d;
         inv_q   <= inv_d;
         sc_q    <= sc_d;
         samt_q  <= samt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (state_q == ST_CAPTURE && state_d == ST_FINISH)
            res_q <= Shift_reg_out;
      end
   end

   assign ShiftControl = sc_q;
   assign Shift_source = src_q;
   assign Shift_amount = 32'(samt_q);
   assign req.busy     = busy_q;
   assign req.done     = done_q;
   assign req.err      = err_q;
   assign req.result   = res_q;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer between the multicycle control unit and the shift register unit.
- Accepts one shift request (op, source, amount) and latches the operands.
- Drives the shift unit's ShiftControl, Shift_source and Shift_amount: one load, then one or more shift steps, then captures Shift_reg_out.
- Returns the result with a one-cycle done pulse, so the control unit issues one request and waits instead of stepping the unit itself.

Parameters:
- AMT_W, 5, width of the shift amount; amounts are taken modulo 2^AMT_W.
- STEP_MAX, 31, largest amount issued in one SHIFT cycle (1..2^AMT_W-1); larger amounts are split into several steps.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = invalid.
- src  input  32  value to be shifted.
- amt  input  AMT_W  shift amount.
- abort  input  1  cancels the operation in progress.
- Shift_reg_out  input  32  current content of the shift unit.
- ShiftControl  output  3  000 = hold/nop, 001 = load, 010 = SLL, 011 = SRL, 100 = SRA.
- Shift_source  output  32  latched src; meaningful during LOAD.
- Shift_amount  output  32  current step amount, zero-extended.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  pulses together with done on an invalid op.
- result  output  32  captured shift result; holds its value until the next successful completion.

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE.
  - ShiftControl = 000; Shift_source, Shift_amount, result = 0.
  - busy, done, err = 0.
  - Internal latches cleared.
- States: IDLE, LOAD, SHIFT, CAPTURE, FINISH.
- All outputs are registered and decoded from state.
- IDLE:
  - On start = 1, latch op, src and amt.
  - op = 11 -> FINISH with err flag set.
  - Otherwise -> LOAD; remaining amount = amt.
  - start while busy is ignored; no queuing.
- LOAD: ShiftControl = 001, Shift_source = latched src, for exactly one cycle.
  - remaining = 0 -> CAPTURE (no SHIFT cycles).
  - Otherwise -> SHIFT.
- SHIFT: each cycle step = min(remaining, STEP_MAX).
  - ShiftControl = 010/011/100 per op; Shift_amount = step.
  - remaining -= step.
  - Stay in SHIFT while the new remaining is nonzero; otherwise -> CAPTURE.
  - Number of SHIFT cycles = ceil(amt / STEP_MAX).
- CAPTURE: ShiftControl = 000; result <= Shift_reg_out at the end of this cycle; -> FINISH.
- FINISH: done = 1 for one cycle; err = 1 only for the invalid-op path; -> IDLE.
  - For invalid op, result is not updated and the shift unit sees only 000.
- Latency from the start-sampling edge to done high: 3 + ceil(amt / STEP_MAX) cycles; 3 cycles when amt = 0; 1 cycle for invalid op.
- A new start is accepted in the cycle after FINISH (back-to-back throughput).
- abort:
  - abort = 1 in any busy state except FINISH -> IDLE at the next edge.
  - ShiftControl = 000 from that edge; no done, no err; result unchanged.
  - In FINISH, abort is ignored and the pulse completes.
  - abort and start together in IDLE: abort wins and the request is dropped.
- reset_n deasserted mid-operation: immediate return to reset values; the operation is lost.
- Shift_amount bits [31:AMT_W] are always 0.
- ShiftControl is never 001 outside LOAD.

Decomposition:
- Shared package holds:
  - ShiftControl encodings (SC_NOP, SC_LOAD, SC_SLL, SC_SRL, SC_SRA).
  - op encodings (OP_SLL, OP_SRL, OP_SRA).
  - State encoding localparams.
- No sub-module needed: the step/remaining computation stays inline.
- The bench reuses the team's existing shift register unit as the downstream model.

Test Plan:
- SLL, src = 0x0000_0003, amt = 4, STEP_MAX = 31 -> ShiftControl sequence 001, 010 (Shift_amount = 4), 000; done 4 cycles after start; result = 0x0000_0030; busy high for 4 cycles before done.
- SRA, src = 0x8000_0000, amt = 31, STEP_MAX = 8 -> four SHIFT cycles with amounts 8, 8, 8, 7; result = 0xFFFF_FFFF; done at cycle 7.
- SRL, src = 0xF000_000F, amt = 0 -> LOAD then CAPTURE only, no 01x/100 codes issued; result = 0xF000_000F; done at cycle 3.
- op = 11 -> done and err pulse together 1 cycle after start; ShiftControl stays 000; result keeps its prior value.
- abort asserted during the second SHIFT step of an amt = 20, STEP_MAX = 4 SLL:
  - -> ShiftControl 000 next cycle; busy low; no done; result unchanged.
  - A following SLL of 0x1 by 1 returns 0x2.
- reset_n pulsed low mid-SHIFT -> all outputs 0 immediately (asynchronous); start pulses during busy are ignored; back-to-back starts issued the cycle after done are both served.
